// File: rtl/numitron_shift_driver_if.sv
// Counter-side bundle for the numitron driver: time values and request in, serial chain out.
interface numitron_shift_driver_if;
  logic [6:0] hours;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic       update;
  logic       blank;
  logic       busy;
  logic       ser_clk;
  logic       ser_data;
  logic       ser_latch;

  modport master (
    output hours, minutes, seconds, update, blank,
    input  busy, ser_clk, ser_data, ser_latch
  );

  modport slave (
    input  hours, minutes, seconds, update, blank,
    output busy, ser_clk, ser_data, ser_latch
  );
endinterface

// File: rtl/numitron_shift_driver.sv
// Converts captured h/m/s to six segment bytes and shifts them MSB-first into a 74HC595-style
// chain, followed by a storage-latch pulse.
module numitron_shift_driver #(
  parameter int unsigned CLK_DIV = 4,
  parameter bit          LZB     = 1'b1
) (
  input logic                   clk,
  input logic                   rstn,
  numitron_shift_driver_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StCapture, StConv, StShift, StLatch} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] SegDash = 8'h40;

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        ser_clk_q, ser_clk_d;
  logic        ser_data_q, ser_data_d;
  logic        ser_latch_q, ser_latch_d;
  logic [6:0]  hours_q, hours_d;
  logic [6:0]  minutes_q, minutes_d;
  logic [6:0]  seconds_q, seconds_d;
  logic        blank_q, blank_d;
  logic [1:0]  idx_q, idx_d;
  logic        sub_q, sub_d;
  logic [6:0]  rem_q, rem_d;
  logic [3:0]  tens_q, tens_d;
  logic [47:0] frame_q, frame_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;

  logic [6:0]  val;
  logic [6:0]  rem_sub;
  logic [3:0]  tens_inc;
  logic        store;
  logic        store_dash;
  logic [3:0]  store_tens;
  logic [3:0]  store_units;
  logic [7:0]  tens_seg;
  logic [7:0]  units_seg;

  function automatic logic [7:0] seg_of(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    busy_d      = busy_q;
    ser_clk_d   = ser_clk_q;
    ser_data_d  = ser_data_q;
    ser_latch_d = ser_latch_q;
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
    blank_d     = blank_q;
    idx_d       = idx_q;
    sub_d       = sub_q;
    rem_d       = rem_q;
    tens_d      = tens_q;
    frame_d     = frame_q;
    div_d       = div_q;
    bit_d       = bit_q;
    store       = 1'b0;
    store_dash  = 1'b0;
    store_tens  = 4'd0;
    store_units = 4'd0;
    tens_seg    = 8'h00;
    units_seg   = 8'h00;

    val      = (idx_q == 2'd0) ? hours_q : (idx_q == 2'd1) ? minutes_q : seconds_q;
    rem_sub  = rem_q - 7'd10;
    tens_inc = tens_q + 4'd1;

    // Requests during a frame (including its final latch cycle) collapse into one follow-on frame.
    if (bus.update && (state_q != StIdle)) pending_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (bus.update || pending_q) begin
          state_d   = StCapture;
          pending_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      StCapture: begin
        hours_d   = bus.hours;
        minutes_d = bus.minutes;
        seconds_d = bus.seconds;
        blank_d   = bus.blank;
        idx_d     = 2'd0;
        sub_d     = 1'b0;
        frame_d   = '0;
        state_d   = StConv;
      end
      StConv: begin
        if (!sub_q) begin
          if (val > 7'd99) begin
            store      = 1'b1;
            store_dash = 1'b1;
          end else if (val < 7'd10) begin
            store       = 1'b1;
            store_units = val[3:0];
          end else begin
            rem_d  = val;
            tens_d = 4'd0;
            sub_d  = 1'b1;
          end
        end else begin
          rem_d  = rem_sub;
          tens_d = tens_inc;
          if (rem_sub < 7'd10) begin
            store       = 1'b1;
            store_tens  = tens_inc;
            store_units = rem_sub[3:0];
            sub_d       = 1'b0;
          end
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = 8'd0;
          if (!ser_clk_q) begin
            ser_clk_d = 1'b1;
          end else begin
            ser_clk_d = 1'b0;
            if (bit_q == 6'd47) begin
              state_d     = StLatch;
              ser_data_d  = 1'b0;
              ser_latch_d = 1'b1;
            end else begin
              bit_d      = bit_q + 6'd1;
              frame_d    = {frame_q[46:0], 1'b0};
              ser_data_d = frame_q[46];
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StLatch: begin
        if (div_q == DivLast) begin
          div_d       = 8'd0;
          ser_latch_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Each finished value shifts two bytes in from the bottom; hours end up in the top 16 bits.
    if (store) begin
      tens_seg  = store_dash ? SegDash : seg_of(store_tens);
      units_seg = store_dash ? SegDash : seg_of(store_units);
      if (LZB && !store_dash && (idx_q == 2'd0) && (store_tens == 4'd0)) tens_seg = 8'h00;
      if (blank_q) begin
        tens_seg  = 8'h00;
        units_seg = 8'h00;
      end
      frame_d = {frame_q[31:0], tens_seg, units_seg};
      if (idx_q == 2'd2) begin
        state_d    = StShift;
        div_d      = 8'd0;
        bit_d      = 6'd0;
        ser_clk_d  = 1'b0;
        ser_data_d = frame_d[47];
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_latch_q <= 1'b0;
      hours_q     <= '0;
      minutes_q   <= '0;
      seconds_q   <= '0;
      blank_q     <= 1'b0;
      idx_q       <= '0;
      sub_q       <= 1'b0;
      rem_q       <= '0;
      tens_q      <= '0;
      frame_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      ser_clk_q   <= ser_clk_d;
      ser_data_q  <= ser_data_d;
      ser_latch_q <= ser_latch_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      blank_q     <= blank_d;
      idx_q       <= idx_d;
      sub_q       <= sub_d;
      rem_q       <= rem_d;
      tens_q      <= tens_d;
      frame_q     <= frame_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.ser_clk   = ser_clk_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_latch = ser_latch_q;

endmodule

// File: tb/tb_numitron_shift_driver.sv
// Bench for numitron_shift_driver: two instances (LZB=1 and LZB=0) share stimulus; the chain
// contents seen at each latch pulse are compared with a digit-arithmetic model.
module tb_numitron_shift_driver;
  localparam int unsigned CLK_DIV = 2;
  localparam logic [7:0] SEG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] hours, minutes, seconds;
  logic       update, blank;

  always #5 clk = ~clk;

  numitron_shift_driver_if bus1();
  numitron_shift_driver_if bus0();

  assign bus1.hours = hours;   assign bus0.hours = hours;
  assign bus1.minutes = minutes; assign bus0.minutes = minutes;
  assign bus1.seconds = seconds; assign bus0.seconds = seconds;
  assign bus1.update = update; assign bus0.update = update;
  assign bus1.blank = blank;   assign bus0.blank = blank;

  numitron_shift_driver #(.CLK_DIV(CLK_DIV), .LZB(1'b1)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
  numitron_shift_driver #(.CLK_DIV(CLK_DIV), .LZB(1'b0)) dut0 (.clk(clk), .rstn(rstn), .bus(bus0));

  int total = 0;
  int bad = 0;

  // Chain model: a 48-bit shift register per DUT, snapshotted at each latch rising edge.
  logic [47:0] sr1 = '0, sr0 = '0, lat1 = '0, lat0 = '0;
  int edges1 = 0, edges0 = 0, nlat1 = 0, nlat0 = 0;
  always @(posedge bus1.ser_clk) begin sr1 = {sr1[46:0], bus1.ser_data}; edges1++; end
  always @(posedge bus0.ser_clk) begin sr0 = {sr0[46:0], bus0.ser_data}; edges0++; end
  always @(posedge bus1.ser_latch) begin lat1 = sr1; nlat1++; end
  always @(posedge bus0.ser_latch) begin lat0 = sr0; nlat0++; end

  int cur1 = 0, cur0 = 0, len1 = 0, len0 = 0, viol = 0;
  logic pd1 = 1'b0, pd0 = 1'b0;
  always @(negedge clk) begin
    if (bus1.ser_latch) cur1++; else if (cur1 != 0) begin len1 = cur1; cur1 = 0; end
    if (bus0.ser_latch) cur0++; else if (cur0 != 0) begin len0 = cur0; cur0 = 0; end
    if ((bus1.ser_data !== pd1) && bus1.ser_clk) viol++;
    if ((bus0.ser_data !== pd0) && bus0.ser_clk) viol++;
    pd1 = bus1.ser_data;
    pd0 = bus0.ser_data;
  end

  function automatic logic [47:0] model(input int h, input int m, input int s, input bit b,
                                        input bit lzb);
    int v[3];
    logic [47:0] f;
    logic [7:0] t, u;
    v[0] = h; v[1] = m; v[2] = s;
    f = '0;
    for (int i = 0; i < 3; i++) begin
      if (v[i] > 99) begin
        t = 8'h40; u = 8'h40;
      end else begin
        t = SEG[v[i] / 10];
        u = SEG[v[i] % 10];
        if (i == 0 && lzb && (v[i] / 10) == 0) t = 8'h00;
      end
      if (b) begin t = 8'h00; u = 8'h00; end
      f = {f[31:0], t, u};
    end
    return f;
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int h, input int m, input int s, input bit b);
    @(negedge clk);
    hours = 7'(h); minutes = 7'(m); seconds = 7'(s); blank = b; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus1.busy && n < 1000) begin @(negedge clk); n++; end
    chk("idle_reached", bus1.busy, 1'b0);
  endtask

  task automatic run_check(input string name, input int h, input int m, input int s,
                           input bit b, input logic [47:0] e1, input logic [47:0] e0,
                           output int first_clk);
    int s1, s0, l1, l0, busy_len;
    s1 = edges1; s0 = edges0; l1 = nlat1; l0 = nlat0;
    chk({name, "_idle_before"}, bus1.busy, 1'b0);
    pulse(h, m, s, b);
    chk({name, "_busy_rise"}, bus1.busy, 1'b1);
    busy_len = 1; first_clk = 0;
    while (bus1.busy && busy_len < 1000) begin
      @(negedge clk);
      if (bus1.busy) busy_len++;
      if (first_clk == 0 && bus1.ser_clk) first_clk = busy_len;
    end
    chk({name, "_busy_fall"}, bus1.busy, 1'b0);
    chk({name, "_latch_with_busy"}, bus1.ser_latch, 1'b0);
    @(negedge clk);
    chk({name, "_data_lzb1"}, lat1, e1);
    chk({name, "_data_lzb0"}, lat0, e0);
    chk({name, "_edges1"}, 48'(edges1 - s1), 48'd48);
    chk({name, "_edges0"}, 48'(edges0 - s0), 48'd48);
    chk({name, "_latches1"}, 48'(nlat1 - l1), 48'd1);
    chk({name, "_latches0"}, 48'(nlat0 - l0), 48'd1);
    chk({name, "_latch_len1"}, 48'(len1), 48'(CLK_DIV));
    chk({name, "_latch_len0"}, 48'(len0), 48'(CLK_DIV));
    // capture + conversion (3..30) + 96*CLK_DIV shift + CLK_DIV latch
    chk({name, "_busy_len"},
        ((busy_len >= 1 + 3 + 97 * int'(CLK_DIV)) && (busy_len <= 1 + 30 + 97 * int'(CLK_DIV))),
        1'b1);
  endtask

  typedef struct {
    int h; int m; int s; bit b;
    logic [47:0] e1; logic [47:0] e0;
  } vec_t;

  vec_t vecs[7];
  int   fcs[7];

  initial begin
    int fc, fc_b, l, s1, n;
    int h, m, s;
    bit b;

    vecs[0] = '{12, 34, 56, 1'b0, 48'h065B4F666D7D, 48'h065B4F666D7D};
    vecs[1] = '{5, 0, 9, 1'b0, 48'h006D3F3F3F6F, 48'h3F6D3F3F3F6F};
    vecs[2] = '{127, 99, 100, 1'b0, 48'h40406F6F4040, 48'h40406F6F4040};
    vecs[3] = '{23, 59, 59, 1'b1, 48'h000000000000, 48'h000000000000};
    vecs[4] = '{23, 59, 59, 1'b0, 48'h5B4F6D6F6D6F, 48'h5B4F6D6F6D6F};
    vecs[5] = '{0, 0, 0, 1'b0, 48'h003F3F3F3F3F, 48'h3F3F3F3F3F3F};
    vecs[6] = '{100, 7, 10, 1'b0, 48'h40403F07063F, 48'h40403F07063F};

    rstn = 1'b0; update = 1'b0; blank = 1'b0;
    hours = '0; minutes = '0; seconds = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus1.busy, 1'b0);
    chk("rst_ser_clk", bus1.ser_clk, 1'b0);
    chk("rst_ser_data", bus1.ser_data, 1'b0);
    chk("rst_ser_latch", bus1.ser_latch, 1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].b,
                vecs[i].e1, vecs[i].e0, fc);
      fcs[i] = fc;
    end

    // Out-of-range values cost no more conversion time than single-digit ones.
    run_check("skip_ref", 0, 99, 0, 1'b0, model(0, 99, 0, 0, 1), model(0, 99, 0, 0, 0), fc_b);
    chk("conv_skip_a", 48'(fcs[2]), 48'(fc_b));
    run_check("skip_all", 127, 127, 127, 1'b0, model(127, 127, 127, 0, 1),
              model(127, 127, 127, 0, 0), fc_b);
    chk("conv_skip_b", 48'(fc_b), 48'(fcs[5]));

    for (int i = 0; i < 8; i++) begin
      h = int'($urandom_range(0, 127));
      m = int'($urandom_range(0, 127));
      s = int'($urandom_range(0, 127));
      b = ($urandom_range(0, 3) == 0);
      run_check($sformatf("rnd%0d", i), h, m, s, b, model(h, m, s, b, 1), model(h, m, s, b, 0),
                fc);
    end

    // Three requests during a frame collapse into one follow-on frame with the latest inputs.
    l = nlat1;
    pulse(10, 20, 30, 1'b0);
    repeat (5) @(negedge clk);
    pulse(11, 21, 31, 1'b0);
    repeat (40) @(negedge clk);
    pulse(13, 23, 33, 1'b1);
    repeat (40) @(negedge clk);
    pulse(42, 52, 17, 1'b0);
    wait_idle();
    @(negedge clk);
    chk("pend_first", lat1, model(10, 20, 30, 0, 1));
    chk("pend_rise", bus1.busy, 1'b1);
    wait_idle();
    @(negedge clk);
    chk("pend_second", lat1, model(42, 52, 17, 0, 1));
    chk("pend_second0", lat0, model(42, 52, 17, 0, 0));
    repeat (300) @(negedge clk);
    chk("pend_no_third", 48'(nlat1 - l), 48'd2);
    chk("pend_idle", bus1.busy, 1'b0);

    // A request in the final latch cycle is kept as pending.
    l = nlat1;
    pulse(1, 2, 3, 1'b0);
    n = 0;
    while (!bus1.ser_latch && n < 1000) begin @(negedge clk); n++; end
    chk("latch_seen", bus1.ser_latch, 1'b1);
    @(negedge clk);
    hours = 7'd4; minutes = 7'd5; seconds = 7'd6; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    chk("edge_gap_idle", bus1.busy, 1'b0);
    @(negedge clk);
    chk("edge_pend_rise", bus1.busy, 1'b1);
    wait_idle();
    @(negedge clk);
    chk("edge_pend_data", lat1, model(4, 5, 6, 0, 1));
    chk("edge_pend_count", 48'(nlat1 - l), 48'd2);

    // Asynchronous reset in the low phase of bit 20 aborts without a latch pulse.
    l = nlat1; s1 = edges1;
    pulse(8, 45, 17, 1'b0);
    n = 0;
    while ((edges1 - s1) < 20 && n < 2000) begin @(negedge clk); n++; end
    chk("reach_bit20", 48'(edges1 - s1), 48'd20);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", bus1.busy, 1'b0);
    chk("arst_ser_clk", bus1.ser_clk, 1'b0);
    chk("arst_ser_data", bus1.ser_data, 1'b0);
    chk("arst_ser_latch", bus1.ser_latch, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_no_latch", 48'(nlat1 - l), 48'd0);
    chk("arst_idle", bus1.busy, 1'b0);
    run_check("post_reset", 8, 45, 17, 1'b0, model(8, 45, 17, 0, 1), model(8, 45, 17, 0, 0), fc);

    chk("data_stable_clk_high", 48'(viol), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
